// File: rtl/pio_edge_irq.sv
// Avalon-MM PIO slave: N-bit output register with atomic set/clear, synchronised
// inputs, per-bit edge capture with write-1-to-clear, and a masked level interrupt.
module pio_edge_irq #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // Reject parameter values outside the supported range at elaboration.
  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
      $error("pio_edge_irq: DATA_WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("pio_edge_irq: SYNC_STAGES must be 2..4");
    end
    if (EDGE_TYPE > 2) begin : g_bad_edge
      $error("pio_edge_irq: EDGE_TYPE must be 0, 1 or 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [BUS_W-1:0]      readdata_q, readdata_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] cap_clr;
  logic                  unused_wdata;

  // Bits of writedata above DATA_WIDTH are intentionally ignored.
  assign unused_wdata = ^(writedata >> DATA_WIDTH);

  always_comb begin
    wr_en          = chipselect & ~write_n;
    wdata          = writedata[DATA_WIDTH-1:0];
    sync           = sync_q[SYNC_STAGES-1];

    sync_d         = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d         = sync;
    data_out_d     = data_out_q;
    irq_mask_d     = irq_mask_q;
    cap_clr        = '0;
    readdata_d     = '0;

    if (EDGE_TYPE == 0) begin
      edge_det = sync & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~sync & prev_q;
    end else begin
      edge_det = sync ^ prev_q;
    end

    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_out_d = wdata;
        ADDR_IRQ_MASK: irq_mask_d = wdata;
        ADDR_EDGE_CAP: cap_clr    = wdata;
        ADDR_OUTSET:   data_out_d = data_out_q | wdata;
        ADDR_OUTCLEAR: data_out_d = data_out_q & ~wdata;
        default:       ;
      endcase
    end

    // A new edge in the same cycle as its clear keeps the bit set.
    edge_capture_d = (edge_capture_q & ~cap_clr) | edge_det;

    // Read mux samples current address every cycle; writes show up on the next read.
    case (address)
      ADDR_DATA:     readdata_d = BUS_W'(sync);
      ADDR_IRQ_MASK: readdata_d = BUS_W'(irq_mask_q);
      ADDR_EDGE_CAP: readdata_d = BUS_W'(edge_capture_q);
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= '0;
      prev_q         <= '0;
      data_out_q     <= RESET_OUT;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      data_out_q     <= data_out_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign out_port = data_out_q;
  assign readdata = readdata_q;
  // Level interrupt straight from registered state, no extra pipeline stage.
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Directed bench for pio_edge_irq: register map, set/clear, edge capture timing,
// clear/edge collision, interrupt masking and asynchronous reset.
module tb_pio_edge_irq;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [31:0] readdata;
  logic        irq;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] rdat;

  pio_edge_irq #(
    .DATA_WIDTH (8),
    .RESET_OUT  (8'hA5),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .out_port  (out_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    address    = 3'd7;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    ticks(2);
    check("rst_out_port", 32'(out_port), 32'h0000_00A5);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick();

    // Synchronised input read, idle address returns zero meanwhile
    in_port = 8'h3C;
    ticks(4);
    check("rd_addr7", readdata, 32'h0);
    bus_read(3'd0, rdat);
    check("rd_data_in", rdat, 32'h0000_003C);
    bus_read(3'd3, rdat);
    check("cap_3c_unmasked", rdat, 32'h0000_003C);
    check("irq_unmasked", 32'(irq), 32'h0);
    in_port = 8'h00;
    ticks(4);
    bus_write(3'd3, 32'h0000_00FF);
    bus_read(3'd3, rdat);
    check("cap_cleared_all", rdat, 32'h0);

    // Output register load, atomic set, atomic clear
    bus_write(3'd0, 32'h0000_00F0);
    check("out_load", 32'(out_port), 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_0005);
    check("out_set", 32'(out_port), 32'h0000_00F5);
    bus_write(3'd5, 32'h0000_0030);
    check("out_clear", 32'(out_port), 32'h0000_00C5);
    bus_read(3'd4, rdat);
    check("rd_outset_zero", rdat, 32'h0);
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, rdat);
    check("rd_reserved_zero", rdat, 32'h0);
    check("out_after_reserved_wr", 32'(out_port), 32'h0000_00C5);

    // Rising edge on bit0 lands exactly three clocks after the input change
    bus_write(3'd2, 32'h0000_0001);
    in_port = 8'h01;
    tick();
    check("irq_lat1", 32'(irq), 32'h0);
    tick();
    check("irq_lat2", 32'(irq), 32'h0);
    tick();
    check("irq_lat3", 32'(irq), 32'h1);
    bus_read(3'd3, rdat);
    check("cap_bit0", rdat, 32'h0000_0001);
    in_port = 8'h00;
    ticks(4);
    bus_read(3'd3, rdat);
    check("cap_no_fall", rdat, 32'h0000_0001);
    bus_write(3'd3, 32'h0);
    check("irq_after_w0", 32'(irq), 32'h1);

    // Write-1-to-clear
    bus_write(3'd3, 32'h0000_0001);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_read(3'd3, rdat);
    check("cap_cleared", rdat, 32'h0);

    // Re-arm bit0, then collide a new edge with its clear: set wins
    in_port = 8'h01;
    ticks(3);
    in_port = 8'h00;
    ticks(4);
    check("irq_rearmed", 32'(irq), 32'h1);
    in_port = 8'h01;
    ticks(2);
    bus_write(3'd3, 32'h0000_0001);
    check("irq_collide", 32'(irq), 32'h1);
    bus_read(3'd3, rdat);
    check("cap_collide", rdat, 32'h0000_0001);
    in_port = 8'h00;
    ticks(4);
    bus_write(3'd3, 32'h0000_0001);
    check("irq_final_clear", 32'(irq), 32'h0);

    // Masked capture on bit3, then unmask
    bus_write(3'd2, 32'h0);
    in_port = 8'h08;
    ticks(4);
    check("irq_masked", 32'(irq), 32'h0);
    bus_read(3'd3, rdat);
    check("cap_bit3", rdat, 32'h0000_0008);
    bus_write(3'd2, 32'h0000_0008);
    check("irq_unmask", 32'(irq), 32'h1);
    bus_write(3'd2, 32'hFFFF_FF00);
    bus_read(3'd2, rdat);
    check("mask_upper_ignored", rdat, 32'h0);
    check("irq_mask_zero", 32'(irq), 32'h0);

    // Asynchronous reset mid-operation
    bus_write(3'd0, 32'h0000_00FF);
    in_port = 8'h0F;
    ticks(4);
    bus_write(3'd2, 32'h0000_000F);
    bus_read(3'd3, rdat);
    check("cap_0f", rdat, 32'h0000_000F);
    check("pre_rst_out", 32'(out_port), 32'h0000_00FF);
    check("pre_rst_irq", 32'(irq), 32'h1);
    #2;
    reset_n = 1'b0;
    in_port = 8'h00;
    #1;
    check("arst_out_port", 32'(out_port), 32'h0000_00A5);
    check("arst_readdata", readdata, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    ticks(2);
    reset_n = 1'b1;
    ticks(4);
    bus_read(3'd3, rdat);
    check("post_rst_cap", rdat, 32'h0);
    bus_read(3'd2, rdat);
    check("post_rst_mask", rdat, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
